// File: rtl/gerador_codigo_pkg.sv
// Shared definitions for the calculator command generator.
// The code constants are the same values the calculator controller decodes.
package gerador_codigo_pkg;

  // Operation codes driven on codigo
  localparam logic [2:0] COD_ENTRADA = 3'b000;
  localparam logic [2:0] COD_SOMA    = 3'b001;
  localparam logic [2:0] COD_SUBTRAI = 3'b010;
  localparam logic [2:0] COD_ACUM    = 3'b011;

  // Bit positions of each button inside the stable-level vector
  localparam int BIT_SOMA    = 0;
  localparam int BIT_SUBTRAI = 1;
  localparam int BIT_ACC     = 2;

  // Command FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ISSUE    = 2'b01,
    SHOW_ACC = 2'b10,
    WAIT_REL = 2'b11
  } estado_t;

  // Number of buttons currently high in a 3-bit level vector
  function automatic logic [1:0] conta_botoes(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/gerador_codigo_debounce_botao.sv
// One push-button front end: two-flop synchronizer followed by a
// counter-based debouncer that holds the button's stable level.
module debounce_botao #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_botao,
  output logic o_estavel
);

  // Counter value at which a persistent difference is accepted
  localparam logic [CNT_W-1:0] LP_ULTIMO = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_syncMeta;
  logic             r_syncOut;
  logic             r_stable;
  logic [CNT_W-1:0] r_count;

  // Bring the raw asynchronous button into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_syncMeta <= 1'b0;
      r_syncOut  <= 1'b0;
    end else begin
      r_syncMeta <= i_botao;
      r_syncOut  <= r_syncMeta;
    end
  end

  // Count consecutive cycles of disagreement; toggle stable once it persists
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_stable <= 1'b0;
    end else if (r_syncOut == r_stable) begin
      r_count <= '0;
    end else if (r_count == LP_ULTIMO) begin
      r_stable <= r_syncOut;
      r_count  <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_estavel = r_stable;

endmodule

// File: rtl/gerador_codigo.sv
// Command generator: turns three raw push-buttons into the codigo stream
// for the calculator controller (one-shot soma/subtrai, held accumulator view).
module gerador_codigo
  import gerador_codigo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_soma,
  input  logic       btn_subtrai,
  input  logic       btn_acc,
  output logic [2:0] codigo,
  output logic       op_pulse,
  output logic       err_multi,
  output logic [7:0] op_count
);

  logic [2:0] w_estavel;
  logic [2:0] r_decisao;
  estado_t    r_state;
  logic [2:0] r_codigo;
  logic       r_opPulse;
  logic       r_errMulti;
  logic [7:0] r_opCount;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debSoma (
    .clk      (clk),
    .reset    (reset),
    .i_botao  (btn_soma),
    .o_estavel(w_estavel[BIT_SOMA])
  );

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debSubtrai (
    .clk      (clk),
    .reset    (reset),
    .i_botao  (btn_subtrai),
    .o_estavel(w_estavel[BIT_SUBTRAI])
  );

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debAcc (
    .clk      (clk),
    .reset    (reset),
    .i_botao  (btn_acc),
    .o_estavel(w_estavel[BIT_ACC])
  );

  // Snapshot all three stable levels together so each FSM decision sees one coherent vector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_decisao <= '0;
    end else begin
      r_decisao <= w_estavel;
    end
  end

  // Command FSM with registered codigo, pulse, error flag and issued-op counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_codigo   <= COD_ENTRADA;
      r_opPulse  <= 1'b0;
      r_errMulti <= 1'b0;
      r_opCount  <= 8'd0;
    end else begin
      r_opPulse  <= 1'b0;
      r_errMulti <= 1'b0;
      case (r_state)
        IDLE: begin
          r_codigo <= COD_ENTRADA;
          if (conta_botoes(r_decisao) > 2'd1) begin
            r_state    <= WAIT_REL;
            r_errMulti <= 1'b1;
          end else if (r_decisao[BIT_SOMA]) begin
            r_state   <= ISSUE;
            r_codigo  <= COD_SOMA;
            r_opPulse <= 1'b1;
            r_opCount <= r_opCount + 8'd1;
          end else if (r_decisao[BIT_SUBTRAI]) begin
            r_state   <= ISSUE;
            r_codigo  <= COD_SUBTRAI;
            r_opPulse <= 1'b1;
            r_opCount <= r_opCount + 8'd1;
          end else if (r_decisao[BIT_ACC]) begin
            r_state  <= SHOW_ACC;
            r_codigo <= COD_ACUM;
          end
        end
        ISSUE: begin
          r_state  <= WAIT_REL;
          r_codigo <= COD_ENTRADA;
        end
        SHOW_ACC: begin
          if (r_decisao[BIT_ACC]) begin
            r_codigo <= COD_ACUM;
          end else begin
            r_state  <= IDLE;
            r_codigo <= COD_ENTRADA;
          end
        end
        WAIT_REL: begin
          r_codigo <= COD_ENTRADA;
          if (r_decisao == 3'b000) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_codigo <= COD_ENTRADA;
        end
      endcase
    end
  end

  assign codigo    = r_codigo;
  assign op_pulse  = r_opPulse;
  assign err_multi = r_errMulti;
  assign op_count  = r_opCount;

endmodule

// File: tb/tb_gerador_codigo.sv
// Self-checking bench for gerador_codigo with default parameters (debounce of 4).
// Edge 0 is the first rising edge that samples a newly driven button level;
// outputs are sampled on the falling edge after each rising edge.
module tb_gerador_codigo;

  logic       clk;
  logic       reset;
  logic       btn_soma;
  logic       btn_subtrai;
  logic       btn_acc;
  logic [2:0] codigo;
  logic       op_pulse;
  logic       err_multi;
  logic [7:0] op_count;

  int nChecks;
  int nFails;
  int expCount;

  typedef struct {
    string      name;
    logic [2:0] btns;       // {acc, subtrai, soma}
    int         holdCycles;
    int         totalCycles;
    logic [2:0] expCode;
    int         firstEdge;
    int         lastEdge;
    int         errEdge;
    int         countDelta;
  } scenario_t;

  scenario_t tabela[8];

  gerador_codigo dut (
    .clk        (clk),
    .reset      (reset),
    .btn_soma   (btn_soma),
    .btn_subtrai(btn_subtrai),
    .btn_acc    (btn_acc),
    .codigo     (codigo),
    .op_pulse   (op_pulse),
    .err_multi  (err_multi),
    .op_count   (op_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive the three raw buttons ({acc, subtrai, soma})
  task automatic applyStimulus(input logic [2:0] btns);
    btn_soma    = btns[0];
    btn_subtrai = btns[1];
    btn_acc     = btns[2];
  endtask

  // Run one table row: press from edge 0, release after holdCycles, check every edge
  task automatic runScenario(input scenario_t s);
    logic       inRange;
    logic [2:0] expCod;
    logic       expPulse;
    @(negedge clk);
    applyStimulus(s.btns);
    for (int k = 0; k < s.totalCycles; k++) begin
      @(negedge clk);
      inRange  = (k >= s.firstEdge) && (k <= s.lastEdge);
      expCod   = inRange ? s.expCode : 3'b000;
      expPulse = inRange && ((s.expCode == 3'b001) || (s.expCode == 3'b010));
      checkOutput($sformatf("%s codigo e%0d", s.name, k), 8'(codigo), 8'(expCod));
      checkOutput($sformatf("%s op_pulse e%0d", s.name, k), 8'(op_pulse), 8'(expPulse));
      checkOutput($sformatf("%s err_multi e%0d", s.name, k), 8'(err_multi), 8'(k == s.errEdge));
      if (k == s.holdCycles - 1) applyStimulus(3'b000);
    end
    expCount = (expCount + s.countDelta) % 256;
    checkOutput($sformatf("%s op_count", s.name), op_count, 8'(expCount));
  endtask

  initial begin
    int pulses;
    int waited;
    nChecks  = 0;
    nFails   = 0;
    expCount = 0;

    tabela[0] = '{"soma",       3'b001, 20, 40, 3'b001,  7,  7, -1, 1};
    tabela[1] = '{"subtrai",    3'b010, 20, 40, 3'b010,  7,  7, -1, 1};
    tabela[2] = '{"glitch3",    3'b001,  3, 20, 3'b000, -1, -2, -1, 0};
    tabela[3] = '{"soma4",      3'b001,  4, 30, 3'b001,  7,  7, -1, 1};
    tabela[4] = '{"acc15",      3'b100, 15, 40, 3'b011,  7, 21, -1, 0};
    tabela[5] = '{"multi",      3'b011, 20, 40, 3'b000, -1, -2,  7, 0};
    tabela[6] = '{"somaPos",    3'b001, 20, 40, 3'b001,  7,  7, -1, 1};
    tabela[7] = '{"accGlitch",  3'b100,  3, 20, 3'b000, -1, -2, -1, 0};

    reset = 1'b1;
    applyStimulus(3'b000);
    repeat (3) @(negedge clk);
    checkOutput("reset codigo", 8'(codigo), 8'h00);
    checkOutput("reset op_pulse", 8'(op_pulse), 8'h00);
    checkOutput("reset err_multi", 8'(err_multi), 8'h00);
    checkOutput("reset op_count", op_count, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) runScenario(tabela[i]);

    // Reset in the middle of an accumulator display, button kept pressed
    @(negedge clk);
    applyStimulus(3'b100);
    waited = 0;
    while (codigo !== 3'b011 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("midAcc reached 011", 8'(codigo), 8'h03);
    reset = 1'b1;
    #1;
    checkOutput("midAcc async codigo", 8'(codigo), 8'h00);
    checkOutput("midAcc async op_count", op_count, 8'h00);
    expCount = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("postReset codigo e%0d", k), 8'(codigo), (k >= 7) ? 8'h03 : 8'h00);
    end
    applyStimulus(3'b000);
    repeat (20) @(negedge clk);
    checkOutput("postReset release codigo", 8'(codigo), 8'h00);

    // 256 separate soma presses: every press issues once and the counter wraps
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int p = 0; p < 256; p++) begin
      applyStimulus(3'b001);
      for (int k = 0; k < 45; k++) begin
        @(negedge clk);
        if (op_pulse === 1'b1) pulses++;
        if (err_multi !== 1'b0) checkOutput("wrap err_multi", 8'(err_multi), 8'h00);
        if (k == 29) applyStimulus(3'b000);
      end
      if (p == 254) checkOutput("wrap op_count 255", op_count, 8'd255);
    end
    checkOutput("wrap pulse total low", 8'(pulses), 8'(256));
    checkOutput("wrap pulse total high", 8'(pulses >> 8), 8'd1);
    checkOutput("wrap op_count", op_count, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Absolute time guard so the run always terminates
  initial begin
    #2ms;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule

// File: doc/gerador_codigo.md
Name: gerador_codigo

Overview:
- Front-end command generator for the synchronous calculator. Converts three raw, asynchronous push-buttons (soma, subtrai, mostra acumulador) into the 3-bit codigo stream consumed by the calculator control FSM.
- Guarantees the encoding the controller relies on:
  - 000 (mostra entrada) when idle.
  - 001/010 for exactly one clock per press, so the accumulator updates once per press.
  - 011 held while the accumulator button stays pressed.
- Sits between board I/O and the calculator controller.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized button must differ from its stable value before the stable value toggles (range 2..65535)
CNT_W, 16, width of the per-button debounce counter; must hold DEBOUNCE_CYCLES-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_soma  input  1  raw button, active-high, asynchronous to clk
btn_subtrai  input  1  raw button, active-high, asynchronous to clk
btn_acc  input  1  raw button, active-high, asynchronous to clk
codigo  output  3  registered operation code to controller: 000 entrada, 001 soma, 010 subtrai, 011 acumulador; 100-111 never driven
op_pulse  output  1  registered; high exactly in cycles where codigo is 001 or 010
err_multi  output  1  registered one-cycle pulse; simultaneous-press rejection
op_count  output  8  registered count of issued 001/010 codes, wraps 255->0

Behaviour:
- Reset (async, any time, including mid-operation):
  - codigo=000, op_pulse=0, err_multi=0, op_count=0.
  - Sync flops, debounce counters and stable values =0; FSM=IDLE.
  - Release is synchronous to the next clk edge.
- Per button:
  - 2-flop synchronizer, then debouncer.
  - Counter increments each cycle sync!=stable. It clears when sync==stable.
  - When the count reaches DEBOUNCE_CYCLES-1 and sync still differs, stable toggles at that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Latency: raw button first sampled high at edge 0 -> codigo changes at edge 3+DEBOUNCE_CYCLES (7 with default).
- FSM states and transitions (decisions use stable values; outputs registered):
  - IDLE: codigo=000.
    - Exactly one stable button high: soma -> ISSUE with 001; subtrai -> ISSUE with 010; acc -> SHOW_ACC.
    - Two or more stable high in the same cycle -> WAIT_REL with err_multi=1 for one cycle, nothing issued.
    - None high -> stay.
  - ISSUE: codigo=001/010 and op_pulse=1 for exactly one cycle; op_count increments. Then unconditionally -> WAIT_REL with codigo=000.
  - SHOW_ACC: codigo=011 while stable acc=1.
    - Other buttons are ignored.
    - Stable acc falls -> IDLE, codigo=000 on that edge.
  - WAIT_REL: codigo=000.
    - Leave to IDLE only when all three stable values are 0.
    - Holding a button therefore never re-issues.
- Pressing a second button while the first is still held in WAIT_REL does not issue. A new op needs all buttons released first.
- Illegal FSM encoding -> IDLE.
- op_count: 8-bit modular increment, no saturation.

Decomposition:
- Shared package gerador_codigo_pkg holds:
  - Code constants COD_ENTRADA=3'b000, COD_SOMA=3'b001, COD_SUBTRAI=3'b010, COD_ACUM=3'b011. The same values are used by the calculator controller.
  - FSM state encodings IDLE, ISSUE, SHOW_ACC, WAIT_REL.
- One sub-module, debounce_botao (synchronizer + counter + stable register), parameterized by DEBOUNCE_CYCLES/CNT_W. It is instantiated three times.

Test Plan:
- Reset mid-SHOW_ACC: hold btn_acc until codigo=011, assert reset -> codigo=000, op_count=0 immediately (asynchronous). After release with btn_acc still high -> 011 again 7 edges later.
- Single press: btn_soma high 20 cycles from edge 0 -> codigo=001 and op_pulse=1 only at edge 7, 000 otherwise; op_count=1. Repeat with btn_subtrai -> 010 once; op_count=2.
- Glitch rejection: btn_soma high for 3 cycles (DEBOUNCE_CYCLES=4) -> codigo stays 000; op_count unchanged.
- Accumulator hold: btn_acc high for 15 cycles -> codigo=011 from edge 7 through the debounced release, then 000; op_pulse never high.
- Simultaneous press: btn_soma and btn_subtrai rise on the same edge -> err_multi pulse at edge 7, codigo stays 000. Release both, press btn_soma alone -> single 001.
- Wrap and no-repeat: 256 separate soma presses, each held 30 cycles -> exactly 256 op_pulse cycles; op_count returns to 0.
